// File: rtl/bfly_combine_pkg.sv
// Shared constants for the radix-2 butterfly recombination core.
// Phase counter width, product store addresses and the done phase.
package bfly_combine_pkg;

    localparam int PHASE_W = 4;

    typedef logic [1:0] addr_t;

    localparam addr_t ADDR_RR = 2'd0;
    localparam addr_t ADDR_IR = 2'd1;
    localparam addr_t ADDR_RI = 2'd2;
    localparam addr_t ADDR_II = 2'd3;

    localparam logic [PHASE_W-1:0] DONE_CNT = '0;

endpackage

// File: rtl/bfly_combine_if.sv
// Data bus between operand muxes/multiplier, this core and the next stage.
// master drives products and in0; slave returns selects and results.
interface bfly_combine_if #(
    parameter int N = 16
);
    logic [N-1:0] i_prod;
    logic [N-1:0] i_in0_re;
    logic [N-1:0] i_in0_im;
    logic         o_sel_in;
    logic         o_sel_tw;
    logic [N-1:0] o_out0_re;
    logic [N-1:0] o_out0_im;
    logic [N-1:0] o_out1_re;
    logic [N-1:0] o_out1_im;
    logic         o_done;

    modport master (
        output i_prod, i_in0_re, i_in0_im,
        input  o_sel_in, o_sel_tw,
        input  o_out0_re, o_out0_im,
        input  o_out1_re, o_out1_im,
        input  o_done
    );

    modport slave (
        input  i_prod, i_in0_re, i_in0_im,
        output o_sel_in, o_sel_tw,
        output o_out0_re, o_out0_im,
        output o_out1_re, o_out1_im,
        output o_done
    );
endinterface

// File: rtl/add3_reg.sv
// Registered three-input adder, result wraps modulo 2^N.
// Async active-low reset clears the sum.
module add3_reg #(
    parameter int N = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] c_i,
    output logic [N-1:0] sum_o
);
    logic [N-1:0] sum_q;
    logic [N-1:0] sum_d;

    assign sum_d = a_i + b_i + c_i;
    assign sum_o = sum_q;

    // Sum register, refreshed every clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sum_q <= '0;
        else         sum_q <= sum_d;
    end
endmodule

// File: rtl/bfly_combine.sv
// Butterfly sequencing: phase counter drives multiplier selects, a
// 4-word store collects in1*tw partials, four adders form the outputs.
module bfly_combine
    import bfly_combine_pkg::*;
#(
    parameter int N = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    bfly_combine_if.slave bus
);
    logic [PHASE_W-1:0] cnt_q;
    logic [PHASE_W-1:0] cnt_d;
    logic [N-1:0]       w_q [4];
    logic [N-1:0]       w_d [4];
    logic [N-1:0]       w_n [4];
    logic               full_q;
    logic               full_d;
    logic               done_q;
    logic               done_d;
    addr_t              addr;
    logic               cap;

    assign addr = cnt_q[3:2];
    assign cap  = (cnt_q[1:0] == 2'd3);

    assign bus.o_sel_in = cnt_q[2];
    assign bus.o_sel_tw = cnt_q[3];
    assign bus.o_done   = done_q;

    for (genvar g = 0; g < 4; g++) begin : g_neg
        assign w_n[g] = ~w_q[g] + N'(1);
    end

    // Next counter, store capture at the last cycle of each phase, done.
    // full_q keeps done quiet until a whole frame has been captured.
    always_comb begin
        cnt_d  = cnt_q + PHASE_W'(1);
        w_d    = w_q;
        full_d = full_q;
        if (cap) begin
            w_d[addr] = bus.i_prod;
            if (addr == ADDR_II) full_d = 1'b1;
        end
        done_d = full_q && (cnt_q == DONE_CNT);
    end

    // Counter, store and done registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < 4; i++) w_q[i] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            done_q <= done_d;
            w_q    <= w_d;
        end
    end

    add3_reg #(.N(N)) u_out0_re (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .a_i    (bus.i_in0_re),
        .b_i    (w_q[ADDR_RR]),
        .c_i    (w_n[ADDR_II]),
        .sum_o  (bus.o_out0_re)
    );

    add3_reg #(.N(N)) u_out0_im (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .a_i    (bus.i_in0_im),
        .b_i    (w_q[ADDR_IR]),
        .c_i    (w_q[ADDR_RI]),
        .sum_o  (bus.o_out0_im)
    );

    add3_reg #(.N(N)) u_out1_re (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .a_i    (bus.i_in0_re),
        .b_i    (w_n[ADDR_RR]),
        .c_i    (w_q[ADDR_II]),
        .sum_o  (bus.o_out1_re)
    );

    add3_reg #(.N(N)) u_out1_im (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .a_i    (bus.i_in0_im),
        .b_i    (w_n[ADDR_IR]),
        .c_i    (w_n[ADDR_RI]),
        .sum_o  (bus.o_out1_im)
    );
endmodule

// File: tb/tb_bfly_combine.sv
// Scoreboard bench for bfly_combine: frames of products are driven by
// the selects, expected sums queued, and checked whenever o_done fires.
module tb_bfly_combine;

    typedef struct packed {
        logic [15:0] o0r;
        logic [15:0] o0i;
        logic [15:0] o1r;
        logic [15:0] o1i;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] P [4];
    int          ecnt = 0;
    int          fi = 0;
    int          checks = 0;
    int          errors = 0;
    int          dones = 0;
    exp_t        sbq [$];

    bfly_combine_if #(.N(16)) bus ();

    bfly_combine #(.N(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // zero-latency multiplier: product chosen by the DUT's selects
    assign bus.i_prod = P[{bus.o_sel_tw, bus.o_sel_in}];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] w0, w1, w2, w3,
                                   input logic [15:0] r, im);
        exp_t m;
        m.o0r = r + w0 - w3;
        m.o0i = im + w1 + w2;
        m.o1r = r - w0 + w3;
        m.o1i = im - w1 - w2;
        return m;
    endfunction

    // products of the frame (W0..W3 order = rr, ir, ri, ii)
    task automatic load_p();
        case (fi)
            0: begin P[0] = 16'h0080; P[1] = 16'h0040;
                     P[2] = 16'h0020; P[3] = 16'h0010; end
            1: begin P[0] = 16'h0001; P[1] = 16'h1234;
                     P[2] = 16'h0111; P[3] = 16'h0000; end
            2: begin P[0] = 16'h8000; P[1] = 16'h0000;
                     P[2] = 16'h0000; P[3] = 16'h0000; end
            default:
                for (int i = 0; i < 4; i++) P[i] = 16'($urandom);
        endcase
    endtask

    task automatic load_in0();
        exp_t e;
        case (fi)
            0: begin bus.i_in0_re = 16'h0100; bus.i_in0_im = 16'h0000; end
            1: begin bus.i_in0_re = 16'h7FFF; bus.i_in0_im = 16'h0005; end
            2: begin bus.i_in0_re = 16'h0000; bus.i_in0_im = 16'hFFFF; end
            default: begin
                bus.i_in0_re = 16'($urandom);
                bus.i_in0_im = 16'($urandom);
            end
        endcase
        e = model(P[0], P[1], P[2], P[3], bus.i_in0_re, bus.i_in0_im);
        sbq.push_back(e);
        fi++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) begin
            ecnt++;
            if (ecnt % 16 == 0)      load_p();
            else if (ecnt % 16 == 1) load_in0();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out0_re"}, bus.o_out0_re, 16'h0);
        chk({tag, "_out0_im"}, bus.o_out0_im, 16'h0);
        chk({tag, "_out1_re"}, bus.o_out1_re, 16'h0);
        chk({tag, "_out1_im"}, bus.o_out1_im, 16'h0);
        chk({tag, "_sel"}, {14'h0, bus.o_sel_tw, bus.o_sel_in}, 16'h0);
        chk({tag, "_done"}, {15'h0, bus.o_done}, 16'h0);
    endtask

    // monitor: select sequence, done timing, and scoreboard pop on done
    always @(negedge clk) begin
        if (rst_n) begin
            int  ph;
            logic dexp;
            exp_t e;
            ph   = ecnt % 16;
            dexp = (ecnt >= 17) && ((ecnt - 17) % 16 == 0);
            chk("sel", {14'h0, bus.o_sel_tw, bus.o_sel_in}, 16'(ph / 4));
            chk("done", {15'h0, bus.o_done}, {15'h0, dexp});
            if (bus.o_done) begin
                dones++;
                if (sbq.size() == 0) begin
                    chk("sb_empty", 16'h1, 16'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("out0_re", bus.o_out0_re, e.o0r);
                    chk("out0_im", bus.o_out0_im, e.o0i);
                    chk("out1_re", bus.o_out1_re, e.o1r);
                    chk("out1_im", bus.o_out1_im, e.o1i);
                end
            end
        end
    end

    initial begin
        bus.i_in0_re = 16'h5A5A;
        bus.i_in0_im = 16'hA5A5;
        for (int i = 0; i < 4; i++) P[i] = 16'hBEEF;
        repeat (5) @(posedge clk);
        #1;
        chk_zero("rst");

        ecnt = 0;
        fi = 0;
        load_p();
        rst_n = 1'b1;

        while (ecnt != 64 + 9) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        sbq.delete();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst_hold");

        ecnt = 0;
        load_p();
        rst_n = 1'b1;
        while (ecnt != 66) step();

        chk("done_count", 16'(dones), 16'd8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
